// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: round-robin arbiter driving the single register-file write port
module rf_wport_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   wn,
  input  logic [NREQ*DW-1:0]   wd,
  output logic [NREQ-1:0]      gnt,
  output logic                 we,
  output logic [NREG-1:0]      wsel,
  output logic [AW-1:0]        wnum,
  output logic [DW-1:0]        wdata,
  output logic                 busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0]     ptr, off, win;
  logic [PW:0]       sum;
  logic [NREQ-1:0]   elig, rot, nxt_gnt;
  logic [2*NREQ-1:0] dbl;
  logic              found, go, multi;
  logic [AW-1:0]     wn_w;
  logic [DW-1:0]     wd_w;
  always_comb begin
    elig = req & ~gnt;
    dbl = {elig, elig} >> ptr;
    rot = dbl[NREQ-1:0];
    found = 1'b0;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = PW'(k);
      end
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
    go = found & ~stall;
    multi = |(elig & (elig - 1'b1));
    wn_w = '0;
    wd_w = '0;
    nxt_gnt = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == PW'(i)) begin
        wn_w = wn[i*AW +: AW];
        wd_w = wd[i*DW +: DW];
        nxt_gnt[i] = go;
      end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      gnt <= '0;
      we <= 1'b0;
      wsel <= '0;
      wnum <= '0;
      wdata <= '0;
      busy <= 1'b0;
      ptr <= '0;
    end else begin
      gnt <= nxt_gnt;
      we <= go && wn_w != '0;
      wsel <= (go && wn_w != '0) ? NREG'(1) << wn_w : '0;
      busy <= found & (stall | multi);
      if (go) begin
        wnum <= wn_w;
        wdata <= wd_w;
        ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed and randomized checks of rf_wport_arbiter against a behavioural model
module tb_rf_wport_arbiter;
  localparam int NREQ = 4, AW = 5, DW = 32, NREG = 32;
  logic clk = 0, clr = 1, stall = 0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] wn = '0;
  logic [NREQ*DW-1:0] wd = '0;
  logic [NREQ-1:0] gnt;
  logic we, busy;
  logic [NREG-1:0] wsel;
  logic [AW-1:0] wnum;
  logic [DW-1:0] wdata;
  int total = 0, bad = 0;
  rf_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .clr(clr), .stall(stall), .req(req), .wn(wn), .wd(wd),
    .gnt(gnt), .we(we), .wsel(wsel), .wnum(wnum), .wdata(wdata), .busy(busy));
  always #5 clk = ~clk;
  logic [NREQ-1:0] m_gnt;
  logic m_we, m_busy;
  logic [NREG-1:0] m_wsel;
  logic [AW-1:0] m_wnum;
  logic [DW-1:0] m_wdata;
  int m_ptr;
  always @(posedge clk) begin
    int n, w, i;
    if (clr) begin
      m_gnt = '0; m_we = 0; m_wsel = '0; m_wnum = '0; m_wdata = '0; m_busy = 0; m_ptr = 0;
    end else begin
      n = 0; w = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (req[i] && !m_gnt[i]) begin
          n++;
          if (w < 0) w = i;
        end
      end
      m_busy = n > 0 && (stall || n > 1);
      if (w >= 0 && !stall) begin
        m_gnt = '0;
        m_gnt[w] = 1'b1;
        m_wnum = wn[w*AW +: AW];
        m_wdata = wd[w*DW +: DW];
        m_we = m_wnum != 0;
        m_wsel = '0;
        if (m_we) m_wsel[m_wnum] = 1'b1;
        m_ptr = (w + 1) % NREQ;
      end else begin
        m_gnt = '0; m_we = 0; m_wsel = '0;
      end
    end
  end
  function automatic logic [74:0] dut_v();
    return {gnt, we, wsel, wnum, wdata, busy};
  endfunction
  function automatic logic [74:0] mdl_v();
    return {m_gnt, m_we, m_wsel, m_wnum, m_wdata, m_busy};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic c, input logic s, input logic [NREQ-1:0] r);
    @(negedge clk);
    clr = c; stall = s; req = r;
  endtask
  task automatic set_distinct();
    for (int i = 0; i < NREQ; i++) begin
      wn[i*AW +: AW] = AW'(i + 3);
      wd[i*DW +: DW] = 32'hA000_0000 + i;
    end
  endtask
  task automatic test_reset();
    set_distinct();
    drive(1, 0, 4'b1111);
    step();
    step();
    total++;
    if ({gnt, we, wsel, wdata, busy, wnum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0", {gnt, we, wsel, wdata, busy, wnum});
    end
    drive(0, 0, 4'b1111);
    step();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b required=0001", gnt); end
  endtask
  task automatic test_single();
    drive(1, 0, '0);
    step();
    wn[2*AW +: AW] = 5'd7;
    wd[2*DW +: DW] = 32'hDEADBEEF;
    drive(0, 0, 4'b0100);
    step();
    total++;
    if ({gnt, we, wsel, wnum, wdata} !== {4'b0100, 1'b1, 32'd1 << 7, 5'd7, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL single_grant got=%h required=%h", {gnt, we, wsel, wnum, wdata}, {4'b0100, 1'b1, 32'd1 << 7, 5'd7, 32'hDEADBEEF});
    end
    drive(0, 0, '0);
    step();
    total++;
    if ({gnt, we} !== 5'b0) begin bad++; $display("FAIL single_drop got=%b required=0", {gnt, we}); end
  endtask
  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    drive(1, 0, '0);
    step();
    set_distinct();
    drive(0, 0, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      step();
      exp_g = 4'b0001 << (c % NREQ);
      total++;
      if (gnt !== exp_g || wnum !== AW'((c % NREQ) + 3) || !we) begin
        bad++;
        $display("FAIL round_robin_%0d got=%b/%0d required=%b/%0d", c, gnt, wnum, exp_g, (c % NREQ) + 3);
      end
    end
  endtask
  task automatic test_reg0();
    drive(1, 0, '0);
    step();
    wn[0 +: AW] = '0;
    wd[0 +: DW] = 32'h1234;
    drive(0, 0, 4'b0001);
    step();
    total++;
    if ({gnt, we, wsel, wnum, wdata} !== {4'b0001, 1'b0, 32'd0, 5'd0, 32'h1234}) begin
      bad++;
      $display("FAIL reg0 got=%h required=%h", {gnt, we, wsel, wnum, wdata}, {4'b0001, 1'b0, 32'd0, 5'd0, 32'h1234});
    end
    drive(0, 0, '0);
    step();
  endtask
  task automatic test_stall();
    drive(1, 0, '0);
    step();
    set_distinct();
    drive(0, 1, 4'b0011);
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({gnt, we, busy} !== 6'b000001) begin bad++; $display("FAIL stall_%0d got=%b required=000001", c, {gnt, we, busy}); end
    end
    drive(0, 0, 4'b0011);
    step();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL stall_release0 got=%b required=0001", gnt); end
    step();
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_release1 got=%b required=0010", gnt); end
  endtask
  task automatic test_clr_mid();
    drive(1, 0, '0);
    step();
    set_distinct();
    drive(0, 0, 4'b1111);
    step();
    step();
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL clr_mid_pre got=%b required=0010", gnt); end
    drive(1, 0, 4'b1111);
    step();
    total++;
    if (dut_v() !== '0) begin bad++; $display("FAIL clr_mid_zero got=%h required=0", dut_v()); end
    drive(0, 0, 4'b1111);
    step();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL clr_mid_restart got=%b required=0001", gnt); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      clr = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        wn[i*AW +: AW] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        wd[i*DW +: DW] = $urandom;
      end
      step();
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++;
        $display("FAIL random_%0d got=%h required=%h", c, dut_v(), mdl_v());
      end
      total++;
      if ((gnt & (gnt - 1'b1)) != 0 || (we && (wsel !== (32'd1 << wnum) || wnum == 0))) begin
        bad++;
        $display("FAIL invariant_%0d got gnt=%b we=%b wsel=%h wnum=%0d required onehot/consistent", c, gnt, we, wsel, wnum);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reg0();
    test_stall();
    test_clr_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
